// File: rtl/dispatcher_pkg.sv
// rtl/dispatcher_pkg.sv - shared types and constants for the MVM dispatcher
// Contents: dispatcher FSM state enum, mode encodings, statistics counter width.
package dispatcher_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UNICAST = 2'd1,
    MCAST   = 2'd2
  } state_t;

  localparam logic MODE_UNICAST = 1'b0;
  localparam logic MODE_MCAST   = 1'b1;

  localparam int STAT_W = 32;

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - single-clock FIFO feeding the dispatcher output stage
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   wr_en/wr_data  push strobe and data; accepted only while wr_rdy is high
//   wr_rdy         registered "not full"; low in reset, high from the first edge after it
//   rd_en          pop strobe; ignored while empty
//   rd_data        head-of-queue word (show-ahead)
//   empty          no words stored
module axis_sync_fifo #(
  parameter int DATAW      = 512,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DATAW-1:0] wr_data,
  output logic             wr_rdy,
  input  logic             rd_en,
  output logic [DATAW-1:0] rd_data,
  output logic             empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATAW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             push, pop;

  // A push is judged against the registered ready only, so a pop in the same
  // cycle never lets a write into a full FIFO.
  assign push    = wr_en && wr_rdy;
  assign pop     = rd_en && !empty;
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_rdy <= 1'b0;
    end else begin
      count  <= count_nxt;
      wr_rdy <= (count_nxt != FULL_CNT);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mvm_dispatcher_mc.sv
// rtl/mvm_dispatcher_mc.sv - FIFO-fed AXI-Stream dispatcher, round-robin unicast or multicast
// Optional feature macro: DISPATCHER_STATS_EN adds stat_beats / stat_pkts counters.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   mode                             0 = round-robin unicast packets, 1 = multicast each word
//   data_fifo_wen/wdata/rdy          input FIFO write port, rdy = not full
//   dest_wen/widx/wdata              destination table write port
//   axis_tx_t{valid,data,last,id,dest,ready}  registered output stream
//   stat_beats, stat_pkts            (DISPATCHER_STATS_EN only) handshake / tlast-handshake counts
module mvm_dispatcher_mc
  import dispatcher_pkg::*;
#(
  parameter int DATAW      = 512,
  parameter int IDW        = 2,
  parameter int DESTW      = 4,
  parameter int NUM_DEST   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mode,
  input  logic                        data_fifo_wen,
  input  logic [DATAW-1:0]            data_fifo_wdata,
  output logic                        data_fifo_rdy,
  input  logic                        dest_wen,
  input  logic [$clog2(NUM_DEST)-1:0] dest_widx,
  input  logic [DESTW-1:0]            dest_wdata,
  output logic                        axis_tx_tvalid,
  output logic [DATAW-1:0]            axis_tx_tdata,
  output logic                        axis_tx_tlast,
  output logic [IDW-1:0]              axis_tx_tid,
  output logic [DESTW-1:0]            axis_tx_tdest,
`ifdef DISPATCHER_STATS_EN
  output logic [STAT_W-1:0]           stat_beats,
  output logic [STAT_W-1:0]           stat_pkts,
`endif
  input  logic                        axis_tx_tready
);

  localparam int IW = $clog2(NUM_DEST);
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DEST - 1);

  state_t           state, state_nxt;
  logic [DESTW-1:0] dest_tab [NUM_DEST];
  logic [IW-1:0]    dest_idx;   // unicast round-robin pointer
  logic [IW-1:0]    mc_idx;     // next multicast copy
  logic [BW-1:0]    beat_cnt;   // next unicast beat within the packet
  logic             fifo_empty, fifo_pop;
  logic [DATAW-1:0] fifo_rdata;
  logic             can_load, boundary, load_uni, load_mc;

  axis_sync_fifo #(
    .DATAW      (DATAW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (data_fifo_wen),
    .wr_data (data_fifo_wdata),
    .wr_rdy  (data_fifo_rdy),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty)
  );

  // The output register can take a new beat when it is empty or its current
  // beat handshakes this cycle.
  assign can_load = !axis_tx_tvalid || axis_tx_tready;
  // Words leave the FIFO as they enter the output register; a multicast word
  // stays at the head until its final copy is issued.
  assign fifo_pop = load_uni || (load_mc && (mc_idx == LAST_IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Mode is only looked at on a packet boundary, so a packet in flight always
  // finishes in the mode it started with.
  always_comb begin
    state_nxt = state;
    load_uni  = 1'b0;
    load_mc   = 1'b0;
    boundary  = (state == IDLE) ||
                ((state == UNICAST) && (beat_cnt == '0)) ||
                ((state == MCAST) && (mc_idx == '0));
    if (can_load) begin
      if (boundary) begin
        if (fifo_empty) begin
          state_nxt = IDLE;
        end else if (mode == MODE_MCAST) begin
          state_nxt = MCAST;
          load_mc   = 1'b1;
        end else begin
          state_nxt = UNICAST;
          load_uni  = 1'b1;
        end
      end else if (!fifo_empty) begin
        load_uni = (state == UNICAST);
        load_mc  = (state == MCAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DEST; i++) dest_tab[i] <= DESTW'(i);
    end else if (dest_wen) begin
      dest_tab[dest_widx] <= dest_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      dest_idx <= '0;
      mc_idx   <= '0;
    end else begin
      if (load_uni) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt <= '0;
          dest_idx <= dest_idx + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (load_mc) mc_idx <= mc_idx + 1'b1;
    end
  end

  // tdest is read from the table register at load time, so a table write in
  // the same cycle to the same entry lands after the latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axis_tx_tvalid <= 1'b0;
      axis_tx_tdata  <= '0;
      axis_tx_tlast  <= 1'b0;
      axis_tx_tid    <= '0;
      axis_tx_tdest  <= '0;
    end else if (load_uni || load_mc) begin
      axis_tx_tvalid <= 1'b1;
      axis_tx_tdata  <= fifo_rdata;
      if (load_mc) begin
        axis_tx_tlast <= 1'b1;
        axis_tx_tid   <= IDW'(mc_idx);
        axis_tx_tdest <= dest_tab[mc_idx];
      end else begin
        axis_tx_tlast <= (beat_cnt == LAST_BEAT);
        // Destination fixed for the whole packet, including across FIFO stalls.
        if (beat_cnt == '0) begin
          axis_tx_tid   <= IDW'(dest_idx);
          axis_tx_tdest <= dest_tab[dest_idx];
        end
      end
    end else if (axis_tx_tready) begin
      axis_tx_tvalid <= 1'b0;
    end
  end

`ifdef DISPATCHER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats <= '0;
      stat_pkts  <= '0;
    end else if (axis_tx_tvalid && axis_tx_tready) begin
      stat_beats <= stat_beats + 1'b1;
      if (axis_tx_tlast) stat_pkts <= stat_pkts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mvm_dispatcher_mc.sv
// tb/tb_mvm_dispatcher_mc.sv - scoreboard bench for mvm_dispatcher_mc (default parameters)
// Optional feature macro: DISPATCHER_STATS_EN also checks the statistics counters.
module tb_mvm_dispatcher_mc;

  localparam int DATAW = 512, IDW = 2, DESTW = 4, NUM_DEST = 4, FIFO_DEPTH = 8, PKT_LEN = 4;

  typedef struct packed {
    logic             last;
    logic [IDW-1:0]   tid;
    logic [DESTW-1:0] dest;
    logic [DATAW-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode = 1'b0;
  logic             data_fifo_wen = 1'b0;
  logic [DATAW-1:0] data_fifo_wdata = '0;
  logic             data_fifo_rdy;
  logic             dest_wen = 1'b0;
  logic [1:0]       dest_widx = '0;
  logic [DESTW-1:0] dest_wdata = '0;
  logic             axis_tx_tvalid;
  logic [DATAW-1:0] axis_tx_tdata;
  logic             axis_tx_tlast;
  logic [IDW-1:0]   axis_tx_tid;
  logic [DESTW-1:0] axis_tx_tdest;
  logic             axis_tx_tready = 1'b0;
`ifdef DISPATCHER_STATS_EN
  logic [31:0]      stat_beats, stat_pkts;
`endif

  beat_t exp_q[$];
  beat_t got, want;
  string phase = "reset";
  int    n_pass = 0;
  int    n_total = 0;

  always #5 clk = ~clk;

  mvm_dispatcher_mc #(
    .DATAW(DATAW), .IDW(IDW), .DESTW(DESTW), .NUM_DEST(NUM_DEST),
    .FIFO_DEPTH(FIFO_DEPTH), .PKT_LEN(PKT_LEN)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mode            (mode),
    .data_fifo_wen   (data_fifo_wen),
    .data_fifo_wdata (data_fifo_wdata),
    .data_fifo_rdy   (data_fifo_rdy),
    .dest_wen        (dest_wen),
    .dest_widx       (dest_widx),
    .dest_wdata      (dest_wdata),
    .axis_tx_tvalid  (axis_tx_tvalid),
    .axis_tx_tdata   (axis_tx_tdata),
    .axis_tx_tlast   (axis_tx_tlast),
    .axis_tx_tid     (axis_tx_tid),
    .axis_tx_tdest   (axis_tx_tdest),
`ifdef DISPATCHER_STATS_EN
    .stat_beats      (stat_beats),
    .stat_pkts       (stat_pkts),
`endif
    .axis_tx_tready  (axis_tx_tready)
  );

  task automatic chk(input string nm, input logic [527:0] act, input logic [527:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic ex(input int d, input int dest, input int tid, input bit last);
    beat_t b;
    b.data = DATAW'(d);
    b.dest = DESTW'(dest);
    b.tid  = IDW'(tid);
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (axis_tx_tvalid && axis_tx_tready) begin
      got = {axis_tx_tlast, axis_tx_tid, axis_tx_tdest, axis_tx_tdata};
      if (exp_q.size() == 0) begin
        chk({phase, "_expected_beat_present"}, 528'(exp_q.size() != 0), 528'(1));
      end else begin
        want = exp_q.pop_front();
        chk({phase, "_beat"}, 528'(got), 528'(want));
      end
    end
  end

  task automatic wr(input int d);
    int n = 0;
    while (!data_fifo_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({phase, "_wr_rdy"}, 528'(data_fifo_rdy), 528'(1));
    data_fifo_wen = 1'b1;
    data_fifo_wdata = DATAW'(d);
    @(posedge clk); #1;
    data_fifo_wen = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({phase, "_drained"}, 528'(exp_q.size()), 528'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("reset_outputs_zero",
        528'({axis_tx_tvalid, axis_tx_tlast, axis_tx_tid, axis_tx_tdest, axis_tx_tdata, data_fifo_rdy}),
        528'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rdy_low_before_first_edge", 528'(data_fifo_rdy), 528'(0));
    @(posedge clk); #1;
    chk("rdy_high_after_first_edge", 528'(data_fifo_rdy), 528'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Two unicast packets; first tvalid one cycle after the capturing edge.
    phase = "unicast8";
    mode = 1'b0;
    axis_tx_tready = 1'b1;
    for (int i = 1; i <= 4; i++) ex(i, 0, 0, i == 4);
    for (int i = 5; i <= 8; i++) ex(i, 1, 1, i == 8);
    data_fifo_wen = 1'b1;
    data_fifo_wdata = DATAW'(1);
    @(posedge clk); #1;
    data_fifo_wen = 1'b0;
    chk("tvalid_low_at_write_edge", 528'(axis_tx_tvalid), 528'(0));
    @(posedge clk); #1;
    chk("tvalid_one_cycle_later", 528'({axis_tx_tvalid, axis_tx_tdata[7:0]}), 528'(9'h101));
    for (int i = 2; i <= 8; i++) wr(i);
    drain();
`ifdef DISPATCHER_STATS_EN
    chk("stat_beats", 528'(stat_beats), 528'(8));
    chk("stat_pkts", 528'(stat_pkts), 528'(2));
`endif

    // Multicast one word to every table entry.
    phase = "mcast";
    mode = 1'b1;
    for (int i = 0; i < 4; i++) ex(32'hA5, i, i, 1'b1);
    wr(32'hA5);
    drain();
    mode = 1'b0;

    // Table entry 3 rewritten to node 9, five unicast packets.
    do_reset();
    phase = "table";
    dest_wen = 1'b1;
    dest_widx = 2'd3;
    dest_wdata = 4'd9;
    @(posedge clk); #1;
    dest_wen = 1'b0;
    begin
      int dests[5] = '{0, 1, 2, 9, 0};
      for (int p = 0; p < 5; p++)
        for (int b = 0; b < 4; b++) ex(32'h100 + p * 4 + b, dests[p], p % 4, b == 3);
      for (int p = 0; p < 5; p++)
        for (int b = 0; b < 4; b++) wr(32'h100 + p * 4 + b);
    end
    drain();

    // Back-pressure: FIFO plus output register fill (9 words), extra write dropped.
    do_reset();
    phase = "full";
    axis_tx_tready = 1'b0;
    for (int i = 1; i <= 9; i++) ex(32'h200 + i, (i - 1) / 4, (i - 1) / 4, i == 4 || i == 8);
    for (int i = 1; i <= 9; i++) wr(32'h200 + i);
    chk("rdy_low_when_full", 528'(data_fifo_rdy), 528'(0));
    data_fifo_wen = 1'b1;
    data_fifo_wdata = DATAW'(32'hDEAD);
    @(posedge clk); #1;
    data_fifo_wen = 1'b0;
    chk("rdy_still_low_after_drop", 528'(data_fifo_rdy), 528'(0));
    axis_tx_tready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    axis_tx_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_mid_packet",
          528'({axis_tx_tvalid, axis_tx_tlast, axis_tx_tid, axis_tx_tdest, axis_tx_tdata[15:0]}),
          528'({1'b1, 1'b0, 2'd0, 4'd0, 16'h0203}));
    end
    axis_tx_tready = 1'b1;
    drain();

    // Mode toggled mid-packet has no effect until the packet boundary.
    do_reset();
    phase = "toggle";
    mode = 1'b0;
    axis_tx_tready = 1'b1;
    for (int i = 1; i <= 4; i++) ex(32'h300 + i, 0, 0, i == 4);
    for (int i = 0; i < 4; i++) ex(32'h55, i, i, 1'b1);
    wr(32'h301);
    wr(32'h302);
    mode = 1'b1;
    wr(32'h303);
    wr(32'h304);
    wr(32'h55);
    drain();

    // Reset mid-packet discards everything and rewinds the round-robin pointer.
    phase = "midreset";
    mode = 1'b0;
    axis_tx_tready = 1'b0;
    for (int i = 1; i <= 6; i++) wr(32'h400 + i);
    do_reset();
    axis_tx_tready = 1'b1;
    for (int i = 1; i <= 4; i++) ex(32'h500 + i, 0, 0, i == 4);
    for (int i = 1; i <= 4; i++) wr(32'h500 + i);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
